// File: rtl/acc_result_viewer_pkg.sv
// acc_result_viewer_pkg
//   Shared definitions for the accumulator result viewer and other LED
//   display blocks: the display FSM state encoding and the board clock rate.
package acc_result_viewer_pkg;

  // Board oscillator frequency in Hz. A dwell of CLOCK_FREQ cycles is one second.
  localparam int CLOCK_FREQ = 50_000_000;

  // Display FSM states. The encoding is shared with other LED display blocks.
  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_HOLD   = 2'd1,
    S_SCROLL = 2'd2
  } view_state_e;

endpackage

// File: rtl/acc_result_viewer_dwell.sv
// dwell_tick_counter
//   Paces how long a value stays on the LEDs. It counts 0..TICK_CNT_MAX-1
//   while en is high and wraps back to 0 by itself. expire is high in the
//   last cycle of each dwell period.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   clear  in   force the count back to 0 (has priority over en)
//   en     in   advance the count this cycle
//   expire out  en & (count == TICK_CNT_MAX-1)
module dwell_tick_counter #(
  parameter int TICK_CNT_MAX = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  // At least one bit so that TICK_CNT_MAX=1 still gives a legal counter.
  localparam int CW = (TICK_CNT_MAX > 1) ? $clog2(TICK_CNT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CNT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_result_viewer.sv
// acc_result_viewer
//   Captures an accumulator result on the rising edge of done, flags whether
//   it equals EXPECTED, and on a show pulse scrolls the captured word out on
//   four LEDs, MSB nibble first, TICK_CNT_MAX cycles per nibble.
//   All outputs are registered.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   done        in   accumulator done level, high while the result is valid
//   acc_result  in   accumulator result, sampled only on the rise of done
//   show        in   one-cycle pulse; starts or restarts the scroll
//   leds        out  LED drive: {3'b000, match} when holding, a nibble when scrolling
//   match       out  captured result == EXPECTED
//   busy        out  high while scrolling
module acc_result_viewer
  import acc_result_viewer_pkg::*;
#(
  parameter int                DWIDTH       = 32,
  parameter int                TICK_CNT_MAX = CLOCK_FREQ,
  parameter logic [DWIDTH-1:0] EXPECTED     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DWIDTH-1:0] acc_result,
  input  logic              show,
  output logic [3:0]        leds,
  output logic              match,
  output logic              busy
);

  localparam int NIBBLES = DWIDTH / 4;
  localparam int NW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [NW-1:0] NIB_MSB = NW'(NIBBLES - 1);

  view_state_e       state_q, state_d;
  logic              done_q;
  logic [DWIDTH-1:0] result_q, result_d;
  logic              match_q, match_d;
  logic [NW-1:0]     nib_idx_q, nib_idx_d;
  logic [3:0]        leds_q, leds_d;
  logic              busy_q, busy_d;

  logic done_rise;
  logic tick_clear;
  logic tick_en;
  logic tick_expire;

  assign done_rise = done & ~done_q;

  // The dwell restarts on any cycle we are not continuing a scroll: outside
  // SCROLL, on an abort, or on a restart so the MSB nibble gets a full dwell.
  assign tick_en    = (state_q == S_SCROLL);
  assign tick_clear = (state_q != S_SCROLL) | ~done | show;

  dwell_tick_counter #(
    .TICK_CNT_MAX(TICK_CNT_MAX)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .en    (tick_en),
    .expire(tick_expire)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT;
      done_q    <= 1'b0;
      result_q  <= '0;
      match_q   <= 1'b0;
      nib_idx_q <= '0;
      leds_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done;
      result_q  <= result_d;
      match_q   <= match_d;
      nib_idx_q <= nib_idx_d;
      leds_q    <= leds_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic. Priority: done low > show > dwell expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (done_rise) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!done)     state_d = S_WAIT;
        else if (show) state_d = S_SCROLL;
      end
      S_SCROLL: begin
        if (!done)                                 state_d = S_WAIT;
        else if (show)                             state_d = S_SCROLL;
        else if (tick_expire && nib_idx_q == '0)   state_d = S_HOLD;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Datapath and output next values. leds/busy are derived from the next
  // state so they change on the same edge as the state itself.
  always_comb begin
    result_d  = result_q;
    match_d   = match_q;
    nib_idx_d = nib_idx_q;
    case (state_q)
      S_WAIT: begin
        if (done_rise) begin
          result_d = acc_result;
          match_d  = (acc_result == EXPECTED);
        end else begin
          result_d = '0;
          match_d  = 1'b0;
        end
        nib_idx_d = '0;
      end
      S_HOLD, S_SCROLL: begin
        if (!done) begin
          result_d  = '0;
          match_d   = 1'b0;
          nib_idx_d = '0;
        end else if (show) begin
          nib_idx_d = NIB_MSB;
        end else if (state_q == S_SCROLL && tick_expire && nib_idx_q != '0) begin
          nib_idx_d = nib_idx_q - 1'b1;
        end
      end
      default: begin
        result_d  = '0;
        match_d   = 1'b0;
        nib_idx_d = '0;
      end
    endcase

    case (state_d)
      S_HOLD:   leds_d = {3'b000, match_d};
      S_SCROLL: leds_d = result_d[int'(nib_idx_d) * 4 +: 4];
      default:  leds_d = 4'b0000;
    endcase
    busy_d = (state_d == S_SCROLL);
  end

  assign leds  = leds_q;
  assign match = match_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_acc_result_viewer.sv
module tb_acc_result_viewer;
  import acc_result_viewer_pkg::*;

  localparam int          DWIDTH   = 32;
  localparam int          TICKS    = 4;
  localparam logic [31:0] EXP_SUM  = 32'h1234_5678;
  localparam int          SCROLL_N = (DWIDTH / 4) * TICKS;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [31:0] acc_result;
  logic        show;
  logic [3:0]  leds;
  logic        match;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected {busy, leds} per cycle of a scroll.
  logic [4:0] exp_q[$];

  acc_result_viewer #(
    .DWIDTH      (DWIDTH),
    .TICK_CNT_MAX(TICKS),
    .EXPECTED    (EXP_SUM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .acc_result(acc_result),
    .show      (show),
    .leds      (leds),
    .match     (match),
    .busy      (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // One clock; outputs are then sampled 1ns after the edge and inputs driven
  // here are seen at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: push the expected leds sequence of a full scroll of word w.
  task automatic push_scroll(input logic [31:0] w);
    logic [31:0] word;
    word = w;
    for (int n = DWIDTH / 4 - 1; n >= 0; n--)
      for (int t = 0; t < TICKS; t++)
        exp_q.push_back({1'b1, word[n*4 +: 4]});
  endtask

  // Compare one scoreboard entry against the current outputs.
  task automatic pop_check(input string name);
    logic [4:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got busy=%0b leds=%h", name, busy, leds);
    end else begin
      e = exp_q.pop_front();
      if ({busy, leds} !== e) begin
        failures++;
        $display("FAIL %s: got busy=%0b leds=%h, expected busy=%0b leds=%h",
                 name, busy, leds, e[4], e[3:0]);
      end
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] e_leds,
                            input logic e_match, input logic e_busy);
    checks++;
    if ({leds, match, busy} !== {e_leds, e_match, e_busy}) begin
      failures++;
      $display("FAIL %s: got leds=%h match=%0b busy=%0b, expected leds=%h match=%0b busy=%0b",
               name, leds, match, busy, e_leds, e_match, e_busy);
    end
  endtask

  task automatic check_state(input string name, input view_state_e e);
    checks++;
    if (dut.state_q !== e) begin
      failures++;
      $display("FAIL %s: got state=%0d, expected %0d", name, dut.state_q, e);
    end
  endtask

  task automatic pulse_show();
    show = 1'b1;
    step();
    show = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b1; acc_result = EXP_SUM; show = 1'b0;
    step();
    check_outs("reset_c1", 4'h0, 1'b0, 1'b0);
    step();
    check_outs("reset_c2", 4'h0, 1'b0, 1'b0);
    check_state("reset_state", S_WAIT);
    rst = 1'b0;
    step();
    check_outs("reset_release_capture", 4'h1, 1'b1, 1'b0);
    check_state("reset_release_state", S_HOLD);
  endtask

  task automatic test_mismatch();
    done = 1'b0;
    step();
    check_outs("mm_wait", 4'h0, 1'b0, 1'b0);
    acc_result = 32'h1234_5679;
    done = 1'b1;
    step();
    check_outs("mm_capture", 4'h0, 1'b0, 1'b0);
    check_state("mm_state", S_HOLD);
    acc_result = EXP_SUM;
    step();
    step();
    check_outs("mm_ignore_change", 4'h0, 1'b0, 1'b0);
    // Show on a mismatch scrolls the actual captured value.
    pulse_show();
    push_scroll(32'h1234_5679);
    for (int i = 0; i < SCROLL_N; i++) begin
      pop_check("mm_scroll");
      step();
    end
    check_outs("mm_scroll_end", 4'h0, 1'b0, 1'b0);
    // Recapture a matching value for the following tests.
    done = 1'b0;
    step();
    acc_result = EXP_SUM;
    done = 1'b1;
    step();
    check_outs("mm_recapture", 4'h1, 1'b1, 1'b0);
  endtask

  task automatic test_show_wait();
    done = 1'b0;
    step();
    pulse_show();
    check_outs("show_in_wait", 4'h0, 1'b0, 1'b0);
    check_state("show_in_wait_state", S_WAIT);
    done = 1'b1;
    step();
    check_outs("show_in_wait_recap", 4'h1, 1'b1, 1'b0);
  endtask

  task automatic test_scroll();
    int busy_cnt;
    busy_cnt = 0;
    pulse_show();
    push_scroll(EXP_SUM);
    for (int i = 0; i < SCROLL_N + 8 && busy; i++) begin
      busy_cnt++;
      pop_check("scroll");
      step();
    end
    checks++;
    if (busy_cnt !== SCROLL_N) begin
      failures++;
      $display("FAIL scroll_busy_len: got %0d, expected %0d", busy_cnt, SCROLL_N);
    end
    check_outs("scroll_end", 4'h1, 1'b1, 1'b0);
    check_state("scroll_end_state", S_HOLD);
    exp_q.delete();
  endtask

  task automatic test_restart();
    pulse_show();
    push_scroll(EXP_SUM);
    // Nibble value 3 occupies cycles 8..11; restart during its 2nd cycle.
    for (int i = 0; i < 10; i++) begin
      pop_check("restart_pre");
      if (i < 9) step();
    end
    pulse_show();
    exp_q.delete();
    push_scroll(EXP_SUM);
    for (int i = 0; i < SCROLL_N; i++) begin
      pop_check("restart_post");
      step();
    end
    check_outs("restart_end", 4'h1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    show = 1'b1;
    step();
    step();
    show = 1'b0;
    push_scroll(EXP_SUM);
    for (int i = 0; i < SCROLL_N; i++) begin
      pop_check("b2b");
      step();
    end
    check_outs("b2b_end", 4'h1, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    pulse_show();
    push_scroll(EXP_SUM);
    // Nibble value 5 occupies cycles 16..19; drop done during cycle 17.
    for (int i = 0; i < 18; i++) begin
      pop_check("abort_pre");
      if (i < 17) step();
    end
    done = 1'b0;
    step();
    exp_q.delete();
    check_outs("abort", 4'h0, 1'b0, 1'b0);
    check_state("abort_state", S_WAIT);
    pulse_show();
    check_outs("abort_show_ignored", 4'h0, 1'b0, 1'b0);
    acc_result = 32'($urandom_range(0, 32'hFFFF)) | 32'h00AB_0000;
    done = 1'b1;
    step();
    check_outs("abort_recap_mismatch", 4'h0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    acc_result = EXP_SUM;
    done = 1'b1;
    step();
    check_outs("abort_recap", 4'h1, 1'b1, 1'b0);
  endtask

  task automatic test_rst_show();
    pulse_show();
    for (int i = 0; i < 5; i++) step();
    check_outs("rs_scrolling", 4'h2, 1'b1, 1'b1);
    rst = 1'b1;
    show = 1'b1;
    step();
    rst = 1'b0;
    show = 1'b0;
    check_outs("rs_reset", 4'h0, 1'b0, 1'b0);
    check_state("rs_reset_state", S_WAIT);
    step();
    check_outs("rs_release", 4'h1, 1'b1, 1'b0);
    check_state("rs_release_state", S_HOLD);
  endtask

  initial begin
    test_reset();
    test_mismatch();
    test_show_wait();
    test_scroll();
    test_restart();
    test_back_to_back();
    test_abort();
    test_rst_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
